// File: rtl/trigger_sequencer_pkg.sv
// Shared types and defaults for the trigger sequencer: FSM state encoding and the
// default width of frame count, gap and timeout quantities.
package trigger_sequencer_pkg;

    localparam int unsigned CNT_W_DEFAULT = 32;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StArm,
        StWaitTrig,
        StGap,
        StDone
    } seq_state_e;

endpackage

// File: rtl/trigger_seq_cnt.sv
// Loadable saturating down-counter with a zero flag; times both the inter-frame gap
// and the trigger-wait timeout of the sequencer.
module trigger_seq_cnt
    import trigger_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_aresetn,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (!i_aresetn) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/trigger_sequencer.sv
// Arms a counter-delayed trigger block repeatedly, collects triggers and paces re-arms.
// Optional trigger-wait timeout enabled by defining TRIGGER_SEQ_TIMEOUT_EN.
module trigger_sequencer
    import trigger_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_frames,
    input  logic [CNT_W-1:0] gap_cycles,
    input  logic [CNT_W-1:0] timeout_cycles,
    input  logic             trigger_in,
    output logic             arm_out,
    output logic             trigger_reset_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] frame_count,
    output logic             timeout
);

    seq_state_e       r_state;
    logic [CNT_W-1:0] r_num_frames;
    logic [CNT_W-1:0] r_gap_cycles;
    logic [CNT_W-1:0] r_frame_count;
    logic             r_arm;
    logic             r_trst;
    logic             r_busy;
    logic             r_done;

    logic             w_cnt_load;
    logic             w_cnt_en;
    logic [CNT_W-1:0] w_cnt_val;
    logic             w_cnt_zero;
    logic [CNT_W-1:0] w_frame_inc;
    logic             w_last_frame;

`ifdef TRIGGER_SEQ_TIMEOUT_EN
    logic [CNT_W-1:0] r_timeout_cycles;
    logic             r_timeout;
    logic             w_expired;

    assign w_expired = (r_timeout_cycles != '0) && w_cnt_zero;
    assign w_cnt_en  = (r_state == StGap) || (r_state == StWaitTrig);
    assign timeout   = r_timeout;
`else
    logic w_unused_timeout_cycles;

    assign w_unused_timeout_cycles = ^timeout_cycles;
    assign w_cnt_en                = (r_state == StGap);
    assign timeout                 = 1'b0;
`endif

    assign w_frame_inc  = r_frame_count + CNT_W'(1);
    assign w_last_frame = (r_num_frames != '0) && (w_frame_inc == r_num_frames);

    // Loaded with N-1 so the state dwells exactly N cycles before the zero flag fires.
    always_comb begin
        w_cnt_load = 1'b0;
        w_cnt_val  = r_gap_cycles - CNT_W'(1);
        if ((r_state == StWaitTrig) && trigger_in) begin
            w_cnt_load = 1'b1;
        end
`ifdef TRIGGER_SEQ_TIMEOUT_EN
        if (r_state == StArm) begin
            w_cnt_load = 1'b1;
            w_cnt_val  = r_timeout_cycles - CNT_W'(1);
        end
`endif
    end

    trigger_seq_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .i_clk      (clk),
        .i_aresetn  (aresetn),
        .i_load     (w_cnt_load),
        .i_en       (w_cnt_en),
        .i_load_val (w_cnt_val),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_state       <= StIdle;
            r_num_frames  <= '0;
            r_gap_cycles  <= '0;
            r_frame_count <= '0;
            r_arm         <= 1'b0;
            r_trst        <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
`ifdef TRIGGER_SEQ_TIMEOUT_EN
            r_timeout_cycles <= '0;
            r_timeout        <= 1'b0;
`endif
        end else begin
            r_arm  <= 1'b0;
            r_trst <= 1'b0;
            r_done <= 1'b0;
            if (abort) begin
                // Abort beats start in IDLE as well, so IDLE simply stays put.
                if (r_state != StIdle) begin
                    r_state <= StIdle;
                    r_trst  <= 1'b1;
                    r_busy  <= 1'b0;
                end
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (start) begin
                            r_num_frames  <= num_frames;
                            r_gap_cycles  <= gap_cycles;
                            r_frame_count <= '0;
`ifdef TRIGGER_SEQ_TIMEOUT_EN
                            r_timeout_cycles <= timeout_cycles;
                            r_timeout        <= 1'b0;
`endif
                            r_state <= StClear;
                            r_trst  <= 1'b1;
                            r_busy  <= 1'b1;
                        end
                    end
                    StClear: begin
                        r_state <= StArm;
                        r_arm   <= 1'b1;
                    end
                    StArm: begin
                        r_state <= StWaitTrig;
                    end
                    StWaitTrig: begin
                        if (trigger_in) begin
                            r_frame_count <= w_frame_inc;
                            if (w_last_frame) begin
                                r_state <= StDone;
                                r_done  <= 1'b1;
                                r_trst  <= 1'b1;
                            end else if (r_gap_cycles == '0) begin
                                // Zero gap skips GAP so re-arm latency stays gap+2.
                                r_state <= StClear;
                                r_trst  <= 1'b1;
                            end else begin
                                r_state <= StGap;
                            end
                        end
`ifdef TRIGGER_SEQ_TIMEOUT_EN
                        else if (w_expired) begin
                            r_timeout <= 1'b1;
                            r_trst    <= 1'b1;
                            r_state   <= StIdle;
                            r_busy    <= 1'b0;
                        end
`endif
                    end
                    StGap: begin
                        if (w_cnt_zero) begin
                            r_state <= StClear;
                            r_trst  <= 1'b1;
                        end
                    end
                    StDone: begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign arm_out           = r_arm;
    assign trigger_reset_out = r_trst;
    assign busy              = r_busy;
    assign done              = r_done;
    assign frame_count       = r_frame_count;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Directed self-checking bench for trigger_sequencer (32-bit and 4-bit instances).
module tb_trigger_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        aresetn = 1'b0;
    logic        start = 1'b0, start4 = 1'b0, abort = 1'b0;
    logic        trigger_in = 1'b0, trigger4 = 1'b0;
    logic [31:0] num_frames = '0, gap_cycles = '0, timeout_cycles = '0;
    logic [3:0]  num4 = '0, gap4 = '0, tmo4 = '0;
    logic        arm_out, trst, busy, done, timeout;
    logic [31:0] frame_count;
    logic        arm4, trst4, busy4, done4, timeout4;
    logic [3:0]  fc4;

    trigger_sequencer dut (
        .clk               (clk),
        .aresetn           (aresetn),
        .start             (start),
        .abort             (abort),
        .num_frames        (num_frames),
        .gap_cycles        (gap_cycles),
        .timeout_cycles    (timeout_cycles),
        .trigger_in        (trigger_in),
        .arm_out           (arm_out),
        .trigger_reset_out (trst),
        .busy              (busy),
        .done              (done),
        .frame_count       (frame_count),
        .timeout           (timeout)
    );

    trigger_sequencer #(.CNT_W(4)) dut4 (
        .clk               (clk),
        .aresetn           (aresetn),
        .start             (start4),
        .abort             (abort),
        .num_frames        (num4),
        .gap_cycles        (gap4),
        .timeout_cycles    (tmo4),
        .trigger_in        (trigger4),
        .arm_out           (arm4),
        .trigger_reset_out (trst4),
        .busy              (busy4),
        .done              (done4),
        .frame_count       (fc4),
        .timeout           (timeout4)
    );

    int n_checks = 0;
    int n_fail = 0;
    int arm_q[$], trst_q[$], done_q[$], rise_q[$];
    int first_idle, last_busy;
    logic [5:0] snap;

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // Start in cycle 0, then observe each cycle at negedge while a trigger-block model
    // raises trigger trig_delay cycles after each arm and drops it on trigger reset.
    task automatic run(input bit sel4, input int budget, input int trig_delay,
                       input int max_trigs, input int abort_at, input int reset_at,
                       input bit disturb);
        int next_rise = -1;
        int n_trigs = 0;
        bit trig = 1'b0;
        logic o_arm, o_trst, o_busy, o_done, o_tmo;
        logic [31:0] o_fc;
        arm_q.delete(); trst_q.delete(); done_q.delete(); rise_q.delete();
        first_idle = -1; last_busy = -1; snap = '0;
        @(negedge clk);
        trigger_in = 1'b0; trigger4 = 1'b0;
        if (sel4) start4 = 1'b1; else start = 1'b1;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clk);
            start = 1'b0; start4 = 1'b0; abort = 1'b0; aresetn = 1'b1;
            o_arm  = sel4 ? arm4 : arm_out;
            o_trst = sel4 ? trst4 : trst;
            o_busy = sel4 ? busy4 : busy;
            o_done = sel4 ? done4 : done;
            o_tmo  = sel4 ? timeout4 : timeout;
            o_fc   = sel4 ? {28'd0, fc4} : frame_count;
            if (o_arm) arm_q.push_back(cyc);
            if (o_trst) trst_q.push_back(cyc);
            if (o_done) done_q.push_back(cyc);
            if (o_busy) last_busy = cyc;
            else if (first_idle < 0) first_idle = cyc;
            if (cyc == reset_at + 1) snap = {o_arm, o_trst, o_busy, o_done, o_tmo, o_fc != 0};
            if (o_trst) trig = 1'b0;
            if (o_arm && n_trigs < max_trigs) next_rise = cyc + trig_delay;
            if (cyc == next_rise) begin
                trig = 1'b1;
                n_trigs++;
                rise_q.push_back(cyc);
            end
            if (sel4) trigger4 = trig; else trigger_in = trig;
            if (cyc == abort_at) abort = 1'b1;
            if (cyc == reset_at) begin
                aresetn = 1'b0;
                start = 1'b1;
            end
            if (disturb) begin
                if (cyc == 1) begin
                    num_frames = 32'd1; gap_cycles = 32'd50; timeout_cycles = 32'd1;
                end
                start = (cyc >= 5 && cyc <= 10);
            end
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({arm_out, trst, busy, done, timeout} !== 5'b0 || frame_count !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got arm=%b trst=%b busy=%b done=%b tmo=%b fc=%0d want all 0",
                     arm_out, trst, busy, done, timeout, frame_count);
        end
        n_checks++;
        if ({arm4, trst4, busy4, done4, timeout4} !== 5'b0 || fc4 !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_outputs4: got arm=%b trst=%b busy=%b done=%b fc=%0d want all 0",
                     arm4, trst4, busy4, done4, fc4);
        end
        aresetn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_reset: busy=%b want 0", busy);
        end
    endtask

    task automatic test_start_abort_idle();
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || trst !== 1'b0) begin
            n_fail++; $display("FAIL start_abort_idle: busy=%b trst=%b want 0 0", busy, trst);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || arm_out !== 1'b0) begin
            n_fail++; $display("FAIL start_abort_idle2: busy=%b arm=%b want 0 0", busy, arm_out);
        end
    endtask

    task automatic test_multi_frame();
        num_frames = 32'd3; gap_cycles = 32'd10; timeout_cycles = 32'd0;
        run(1'b0, 100, 20, 3, -1, -1, 1'b0);
        n_checks++;
        if (arm_q.size() !== 3) begin
            n_fail++; $display("FAIL multi_arm_count: got %0d want 3", arm_q.size());
        end
        n_checks++;
        if (qget(arm_q, 0) !== 2) begin
            n_fail++; $display("FAIL start_to_arm: got cycle %0d want 2", qget(arm_q, 0));
        end
        n_checks++;
        if (qget(arm_q, 1) - qget(arm_q, 0) !== 32 || qget(arm_q, 2) - qget(arm_q, 1) !== 32) begin
            n_fail++; $display("FAIL arm_spacing: got %0d,%0d,%0d want 2,34,66",
                               qget(arm_q, 0), qget(arm_q, 1), qget(arm_q, 2));
        end
        n_checks++;
        if (done_q.size() !== 1 || qget(done_q, 0) !== 87) begin
            n_fail++; $display("FAIL multi_done: got %0d pulses first at %0d want 1 at 87",
                               done_q.size(), qget(done_q, 0));
        end
        n_checks++;
        if (trst_q.size() !== 4 || qget(trst_q, 1) !== 33) begin
            n_fail++; $display("FAIL multi_trst: got %0d pulses second at %0d want 4 at 33",
                               trst_q.size(), qget(trst_q, 1));
        end
        n_checks++;
        if (frame_count !== 32'd3) begin
            n_fail++; $display("FAIL multi_frame_count: got %0d want 3", frame_count);
        end
        n_checks++;
        if (first_idle !== 88) begin
            n_fail++; $display("FAIL multi_idle: got cycle %0d want 88", first_idle);
        end
    endtask

    task automatic test_zero_gap();
        num_frames = 32'd2; gap_cycles = 32'd0; timeout_cycles = 32'd0;
        run(1'b0, 14, 3, 2, -1, -1, 1'b0);
        n_checks++;
        if (qget(arm_q, 1) - qget(rise_q, 0) !== 2) begin
            n_fail++; $display("FAIL zero_gap_rearm: got arm %0d rise %0d want distance 2",
                               qget(arm_q, 1), qget(rise_q, 0));
        end
        n_checks++;
        if (done_q.size() !== 1 || qget(done_q, 0) !== 11) begin
            n_fail++; $display("FAIL zero_gap_done: got %0d at %0d want 1 at 11",
                               done_q.size(), qget(done_q, 0));
        end
        n_checks++;
        if (frame_count !== 32'd2) begin
            n_fail++; $display("FAIL zero_gap_count: got %0d want 2", frame_count);
        end
    endtask

    task automatic test_busy_ignore();
        num_frames = 32'd2; gap_cycles = 32'd2; timeout_cycles = 32'd0;
        run(1'b0, 18, 3, 2, -1, -1, 1'b1);
        n_checks++;
        if (arm_q.size() !== 2 || qget(arm_q, 1) !== 9) begin
            n_fail++; $display("FAIL busy_cfg_arm: got %0d arms second at %0d want 2 at 9",
                               arm_q.size(), qget(arm_q, 1));
        end
        n_checks++;
        if (done_q.size() !== 1 || qget(done_q, 0) !== 13) begin
            n_fail++; $display("FAIL busy_cfg_done: got %0d at %0d want 1 at 13",
                               done_q.size(), qget(done_q, 0));
        end
        n_checks++;
        if (frame_count !== 32'd2 || timeout !== 1'b0) begin
            n_fail++; $display("FAIL busy_cfg_count: fc=%0d tmo=%b want 2 0", frame_count, timeout);
        end
        n_checks++;
        if (first_idle !== 14 || last_busy !== 13) begin
            n_fail++; $display("FAIL busy_start_ignored: idle %0d last busy %0d want 14 13",
                               first_idle, last_busy);
        end
    endtask

    task automatic test_stale_trigger();
        num_frames = 32'd1; gap_cycles = 32'd0; timeout_cycles = 32'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (arm_out !== 1'b1) begin
            n_fail++; $display("FAIL stale_arm: arm=%b want 1", arm_out);
        end
        trigger_in = 1'b1;
        @(negedge clk);
        trigger_in = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (frame_count !== 32'd0 || done !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL stale_ignored: fc=%0d done=%b busy=%b want 0 0 1",
                               frame_count, done, busy);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL stale_abort: busy=%b want 0", busy);
        end
    endtask

    task automatic test_abort();
        num_frames = 32'd1; gap_cycles = 32'd0; timeout_cycles = 32'd0;
        run(1'b0, 12, 5, 0, 7, -1, 1'b0);
        n_checks++;
        if (trst_q.size() !== 2 || qget(trst_q, 1) !== 8) begin
            n_fail++; $display("FAIL abort_trst: got %0d pulses second at %0d want 2 at 8",
                               trst_q.size(), qget(trst_q, 1));
        end
        n_checks++;
        if (first_idle !== 8) begin
            n_fail++; $display("FAIL abort_busy: idle at %0d want 8", first_idle);
        end
        n_checks++;
        if (done_q.size() !== 0 || frame_count !== 32'd0) begin
            n_fail++; $display("FAIL abort_done: done=%0d fc=%0d want 0 0", done_q.size(), frame_count);
        end
        n_checks++;
        if (arm_q.size() !== 1) begin
            n_fail++; $display("FAIL abort_arm: got %0d arms want 1", arm_q.size());
        end
    endtask

    task automatic test_timeout();
        num_frames = 32'd1; gap_cycles = 32'd0; timeout_cycles = 32'd100;
`ifdef TRIGGER_SEQ_TIMEOUT_EN
        run(1'b0, 110, 1, 0, -1, -1, 1'b0);
        n_checks++;
        if (first_idle !== 103 || timeout !== 1'b1) begin
            n_fail++; $display("FAIL timeout_expire: idle %0d tmo=%b want 103 1", first_idle, timeout);
        end
        n_checks++;
        if (trst_q.size() !== 2 || qget(trst_q, 1) !== 103 || done_q.size() !== 0) begin
            n_fail++; $display("FAIL timeout_trst: %0d pulses second at %0d done %0d want 2 103 0",
                               trst_q.size(), qget(trst_q, 1), done_q.size());
        end
        timeout_cycles = 32'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (timeout !== 1'b0) begin
            n_fail++; $display("FAIL timeout_clear: tmo=%b want 0", timeout);
        end
`else
        run(1'b0, 150, 1, 0, -1, -1, 1'b0);
        n_checks++;
        if (first_idle !== -1 || timeout !== 1'b0) begin
            n_fail++; $display("FAIL no_timeout: idle at %0d tmo=%b want -1 0", first_idle, timeout);
        end
`endif
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL timeout_cleanup: busy=%b want 0", busy);
        end
    endtask

    task automatic test_wrap();
        num4 = 4'd0; gap4 = 4'd1; tmo4 = 4'd0;
        run(1'b1, 90, 1, 20, -1, -1, 1'b0);
        n_checks++;
        if (rise_q.size() !== 20) begin
            n_fail++; $display("FAIL wrap_triggers: got %0d want 20", rise_q.size());
        end
        n_checks++;
        if (done_q.size() !== 0 || last_busy !== 90) begin
            n_fail++; $display("FAIL wrap_continuous: done=%0d last busy %0d want 0 90",
                               done_q.size(), last_busy);
        end
        n_checks++;
        if (fc4 !== 4'd4) begin
            n_fail++; $display("FAIL wrap_count: got %0d want 4", fc4);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++;
        if (busy4 !== 1'b0 || trst4 !== 1'b1) begin
            n_fail++; $display("FAIL wrap_abort: busy=%b trst=%b want 0 1", busy4, trst4);
        end
        n_checks++;
        if (trst !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL idle_abort_ignored: trst=%b busy=%b want 0 0", trst, busy);
        end
        @(negedge clk);
        n_checks++;
        if (trst4 !== 1'b0 || fc4 !== 4'd4) begin
            n_fail++; $display("FAIL wrap_after_abort: trst=%b fc=%0d want 0 4", trst4, fc4);
        end
    endtask

    task automatic test_reset_mid_gap();
        num_frames = 32'd2; gap_cycles = 32'd10; timeout_cycles = 32'd0;
        run(1'b0, 16, 2, 2, -1, 8, 1'b0);
        n_checks++;
        if (snap !== 6'b0) begin
            n_fail++; $display("FAIL gap_reset_outputs: got %b want 000000", snap);
        end
        n_checks++;
        if (first_idle !== 9 || last_busy !== 8) begin
            n_fail++; $display("FAIL gap_reset_idle: idle %0d last busy %0d want 9 8",
                               first_idle, last_busy);
        end
        n_checks++;
        if (arm_q.size() !== 1 || trst_q.size() !== 1 || done_q.size() !== 0) begin
            n_fail++; $display("FAIL gap_reset_pulses: arm %0d trst %0d done %0d want 1 1 0",
                               arm_q.size(), trst_q.size(), done_q.size());
        end
        n_checks++;
        if (frame_count !== 32'd0) begin
            n_fail++; $display("FAIL gap_reset_count: got %0d want 0", frame_count);
        end
        trigger_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_start_abort_idle();
        test_multi_frame();
        test_zero_gap();
        test_busy_ignore();
        test_stale_trigger();
        test_abort();
        test_timeout();
        test_wrap();
        test_reset_mid_gap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
